// File: rtl/pw_utmi_tx.sv
// UTMI transmit engine: sends a buffered USB packet (PID + payload) over the
// UTMI TxValid/TxReady handshake, optionally appending the USB CRC16.
module pw_utmi_tx #(
    parameter int unsigned pBUF_BYTES = 64,
    parameter int unsigned pSETTLE    = 4,
    parameter int unsigned pTIMEOUT   = 1023
) (
    input  logic       fe_clk,
    input  logic       reset_n,
    input  logic       I_buf_wr,
    input  logic [5:0] I_buf_addr,
    input  logic [7:0] I_buf_data,
    input  logic [6:0] I_len,
    input  logic       I_crc_en,
    input  logic       I_start,
    input  logic       I_abort,
    input  logic       I_txready,
    output logic       O_txvalid,
    output logic [7:0] O_data,
    output logic       O_drive,
    output logic       O_busy,
    output logic       O_done,
    output logic [1:0] O_error
);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StData,
        StCrcLo,
        StCrcHi,
        StFinish
    } state_t;

    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrLen     = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;
    localparam logic [1:0] ErrAbort   = 2'd3;

    state_t      state_q;
    logic [7:0]  buf_mem [pBUF_BYTES];
    logic [6:0]  len_q;
    logic        crc_en_q;
    logic [5:0]  byte_idx_q;
    logic [15:0] settle_cnt_q;
    logic [15:0] wait_cnt_q;
    logic [15:0] crc_q;

    logic        len_ok;
    logic        consume;
    logic        last_byte;
    logic        wait_expired;
    logic [15:0] crc_next;

    // One byte of the reflected USB CRC16 (poly 0xA001), LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Handshake and bookkeeping decodes shared by the sending states.
    always_comb begin
        len_ok       = (I_len != 7'd0) && (32'(I_len) <= pBUF_BYTES);
        consume      = O_txvalid & I_txready;
        last_byte    = ({1'b0, byte_idx_q} == (len_q - 7'd1));
        wait_expired = (wait_cnt_q == 16'(pTIMEOUT - 1));
        // PID (index 0) is excluded from the CRC.
        crc_next     = (byte_idx_q != 6'd0) ? crc16_byte(crc_q, O_data) : crc_q;
    end

    // Packet buffer: writable only while idle; contents are not reset.
    always_ff @(posedge fe_clk) begin
        if (I_buf_wr && (state_q == StIdle)) begin
            buf_mem[I_buf_addr] <= I_buf_data;
        end
    end

    // Transmit FSM with registered outputs.
    always_ff @(posedge fe_clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            len_q        <= 7'd0;
            crc_en_q     <= 1'b0;
            byte_idx_q   <= 6'd0;
            settle_cnt_q <= 16'd0;
            wait_cnt_q   <= 16'd0;
            crc_q        <= 16'd0;
            O_txvalid    <= 1'b0;
            O_data       <= 8'h00;
            O_drive      <= 1'b0;
            O_busy       <= 1'b0;
            O_done       <= 1'b0;
            O_error      <= ErrOk;
        end else begin
            O_done <= 1'b0;
            // Abort wins over any byte consumption on the same edge.
            if (I_abort && O_busy) begin
                state_q   <= StFinish;
                O_txvalid <= 1'b0;
                O_drive   <= 1'b0;
                O_busy    <= 1'b0;
                O_done    <= 1'b1;
                O_error   <= ErrAbort;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (I_start) begin
                            if (len_ok) begin
                                len_q        <= I_len;
                                crc_en_q     <= I_crc_en;
                                settle_cnt_q <= 16'd0;
                                O_busy       <= 1'b1;
                                O_drive      <= 1'b1;
                                O_error      <= ErrOk;
                                state_q      <= StSettle;
                            end else begin
                                O_error <= ErrLen;
                                O_done  <= 1'b1;
                            end
                        end
                    end
                    StSettle: begin
                        if (settle_cnt_q == 16'(pSETTLE - 1)) begin
                            state_q    <= StData;
                            O_txvalid  <= 1'b1;
                            O_data     <= buf_mem[0];
                            byte_idx_q <= 6'd0;
                            wait_cnt_q <= 16'd0;
                            crc_q      <= 16'hFFFF;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 16'd1;
                        end
                    end
                    StData: begin
                        if (consume) begin
                            wait_cnt_q <= 16'd0;
                            crc_q      <= crc_next;
                            if (!last_byte) begin
                                byte_idx_q <= byte_idx_q + 6'd1;
                                O_data     <= buf_mem[byte_idx_q + 6'd1];
                            end else if (crc_en_q) begin
                                state_q <= StCrcLo;
                                O_data  <= ~crc_next[7:0];
                            end else begin
                                state_q   <= StFinish;
                                O_txvalid <= 1'b0;
                                O_drive   <= 1'b0;
                                O_busy    <= 1'b0;
                                O_done    <= 1'b1;
                            end
                        end else if (wait_expired) begin
                            state_q   <= StFinish;
                            O_txvalid <= 1'b0;
                            O_drive   <= 1'b0;
                            O_busy    <= 1'b0;
                            O_done    <= 1'b1;
                            O_error   <= ErrTimeout;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 16'd1;
                        end
                    end
                    StCrcLo: begin
                        if (consume) begin
                            wait_cnt_q <= 16'd0;
                            state_q    <= StCrcHi;
                            O_data     <= ~crc_q[15:8];
                        end else if (wait_expired) begin
                            state_q   <= StFinish;
                            O_txvalid <= 1'b0;
                            O_drive   <= 1'b0;
                            O_busy    <= 1'b0;
                            O_done    <= 1'b1;
                            O_error   <= ErrTimeout;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 16'd1;
                        end
                    end
                    StCrcHi: begin
                        if (consume || wait_expired) begin
                            state_q    <= StFinish;
                            wait_cnt_q <= 16'd0;
                            O_txvalid  <= 1'b0;
                            O_drive    <= 1'b0;
                            O_busy     <= 1'b0;
                            O_done     <= 1'b1;
                            if (!consume) begin
                                O_error <= ErrTimeout;
                            end
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 16'd1;
                        end
                    end
                    StFinish: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pw_utmi_tx.md
PW_UTMI_TX -- requirements
Module: pw_utmi_tx

Interface
REQ-001 Parameters: pBUF_BYTES (64, packet buffer depth incl. PID); pSETTLE (4, fe_clk cycles of O_drive before first O_txvalid); pTIMEOUT (1023, max cycles waiting on one I_txready).
REQ-002 One clock (fe_clk); reset is synchronous and active-low (reset_n); all ports and state sampled on rising fe_clk.
REQ-003 fe_clk  in  1  UTMI 60 MHz front-end clock.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 I_buf_wr  in  1  write strobe, packet buffer.
REQ-006 I_buf_addr  in  6  buffer byte address.
REQ-007 I_buf_data  in  8  buffer write byte.
REQ-008 I_len  in  7  packet byte count incl. PID, excl. CRC; legal 1..pBUF_BYTES.
REQ-009 I_crc_en  in  1  append CRC16 over bytes 1..I_len-1.
REQ-010 I_start  in  1  single-cycle send request.
REQ-011 I_abort  in  1  abort current send.
REQ-012 I_txready  in  1  UTMI TxReady.
REQ-013 O_txvalid  out  1  UTMI TxValid.
REQ-014 O_data  out  8  UTMI DataIn.
REQ-015 O_drive  out  1  request top to switch opmode to normal (00) and xcvr to drive.
REQ-016 O_busy  out  1  high from accepted start until return to IDLE.
REQ-017 O_done  out  1  one-cycle pulse on completion, abort or error.
REQ-018 O_error  out  2  sticky until next accepted start: 0 ok, 1 bad length, 2 timeout, 3 aborted.

Function
REQ-019 States: IDLE, SETTLE, DATA, CRC_LO, CRC_HI, FINISH.
REQ-020 IDLE: I_buf_wr writes I_buf_data to buffer[I_buf_addr]; writes when O_busy=1 ignored.
REQ-021 IDLE + I_start + I_len in 1..pBUF_BYTES: latch I_len, I_crc_en; O_busy=1, O_drive=1, O_error=0, settle counter cleared; -> SETTLE.
REQ-022 IDLE + I_start + I_len 0 or >pBUF_BYTES: no transmission, O_error=1, O_done pulse next cycle, stay IDLE.
REQ-023 I_start while O_busy=1 ignored.
REQ-024 SETTLE: after pSETTLE cycles -> DATA with O_txvalid=1, O_data=buffer[0].
REQ-025 Handshake: O_data held stable while O_txvalid=1 and I_txready=0; byte consumed on edge where O_txvalid=1 and I_txready=1; next byte presented the following cycle, O_txvalid stays 1 (back-to-back, one byte per cycle when I_txready held high).
REQ-026 DATA: after byte I_len-1 consumed -> CRC_LO if crc enabled, else FINISH.
REQ-027 CRC16: USB polynomial 0x8005 reflected (0xA001), init 0xFFFF, bytes LSB first, updated per consumed byte with index >=1 (PID excluded); transmitted value is ones' complement.
REQ-028 CRC_LO presents low complemented CRC byte, CRC_HI high byte, same handshake; after high byte consumed -> FINISH.
REQ-029 I_len=1 with crc enabled: CRC of empty payload sent (0x00, 0x00 = ~0xFFFF).
REQ-030 FINISH: O_txvalid=0, O_drive=0, O_busy=0, O_done=1 for one cycle, -> IDLE.
REQ-031 Timeout: per-byte wait counter clears on each consumed byte; reaching pTIMEOUT without I_txready -> O_error=2, FINISH.
REQ-032 I_abort while O_busy=1 (any state) -> O_error=3, FINISH next cycle; O_txvalid low next cycle. Abort takes priority over byte consumption on the same edge; I_abort in IDLE ignored.
REQ-033 Reading buffer during send uses latched length; buffer contents unaffected by send.

Reset
REQ-034 reset_n=0 at rising edge: state IDLE; O_txvalid, O_drive, O_busy, O_done = 0; O_data=0x00; O_error=0; counters and CRC cleared; buffer contents undefined.
REQ-035 Reset asserted mid-send: O_txvalid and O_drive low after that edge, no O_done pulse.

Verification
REQ-036 Buffer C3 31 32 33 34 35 36 37 38 39, I_len=10, crc on, I_txready=1 -> O_drive 1, txvalid after 4 cycles, 12 bytes C3 31..39 C8 B4 on consecutive cycles, O_done, O_error=0.
REQ-037 Same packet, I_txready toggling 1-of-3 cycles -> identical byte sequence, O_data stable during every stall.
REQ-038 I_len=1, PID 0xD2, crc off -> single byte D2, done; crc on -> D2 00 00.
REQ-039 I_len=0 and I_len=65 -> no txvalid, O_error=1, O_done one cycle after start.
REQ-040 I_txready held 0 -> O_txvalid drops after 1023 wait cycles, O_error=2; I_abort during byte 3 -> txvalid low next cycle, O_error=3.
REQ-041 reset_n low during DATA -> all outputs 0 next cycle, no O_done; subsequent start sends normally.
